// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: one outstanding imem request at a time, fetched
// {PC, instruction} pairs buffered in a small circular FIFO for decode.
module if_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] FetchPC,
    output logic        PCFrozen,
    input  logic        Flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IR,
    output logic [31:0] IRPC,
    output logic        IRValid,
    input  logic        IDStall
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic [31:0]       addr_q, addr_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  count_after;
    logic [31:0]       pc_mem_q [DEPTH];
    logic [31:0]       ir_mem_q [DEPTH];
    logic              push;
    logic              pop;
    logic              has_data;

    // A flush both discards the returning word and cancels any pop this cycle.
    assign push        = (state_q == REQ) && imem_ack && !Flush;
    assign has_data    = (count_q != '0);
    assign pop         = has_data && !IDStall && !Flush;
    assign count_after = count_q + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            pc_mem_q[tail_q] <= addr_q;
            ir_mem_q[tail_q] <= imem_rdata;
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_after;
        if (Flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PTR_W'(1);
            if (pop)  head_d = head_q + PTR_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (!Flush && (count_q < FULL)) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    addr_d  = {FetchPC[31:2], 2'b00};
                end
            end
            REQ: begin
                if (imem_ack) begin
                    // Keep streaming only while the post-update occupancy leaves room.
                    if (!Flush && (count_after < FULL)) begin
                        addr_d = addr_q + 32'd4;
                    end else begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                    end
                end else if (Flush) begin
                    state_d = DROP;
                    req_d   = 1'b0;
                end
            end
            DROP: begin
                if (imem_ack) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        PCFrozen = 1'b1;
        if (Reset && (Flush || ((state_q == REQ) && imem_ack))) PCFrozen = 1'b0;
        IRValid = has_data;
        IR      = '0;
        IRPC    = '0;
        if (has_data) begin
            IR   = ir_mem_q[head_q];
            IRPC = pc_mem_q[head_q];
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;

    a_no_push_when_full: assert property (@(posedge CLK) disable iff (!Reset)
        !(push && (count_q == FULL)));

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: queue-based reference model checked every cycle,
// a latency-configurable memory, a PC register, and directed scenarios.
module tb_if_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        CLK        = 1'b0;
    logic        Reset      = 1'b0;
    logic [31:0] FetchPC;
    logic        PCFrozen;
    logic        Flush      = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack   = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] IR;
    logic [31:0] IRPC;
    logic        IRValid;
    logic        IDStall    = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    always #5 CLK = ~CLK;

    if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .CLK(CLK), .Reset(Reset), .FetchPC(FetchPC), .PCFrozen(PCFrozen),
        .Flush(Flush), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .IR(IR), .IRPC(IRPC),
        .IRValid(IRValid), .IDStall(IDStall)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'd7) ^ 32'hA5A5_5A5A;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // PC register: loads the redirect target on Flush, advances when not frozen.
    logic [31:0] flush_target = 32'h0;
    logic        pcf_s        = 1'b1;
    always @(negedge CLK) pcf_s = PCFrozen;
    always @(posedge CLK or negedge Reset) begin
        if (!Reset)       FetchPC <= RESET_PC;
        else if (Flush)   FetchPC <= flush_target;
        else if (!pcf_s)  FetchPC <= FetchPC + 32'd4;
    end

    // Memory: accepts a request when idle, acks in the lat-th cycle; not reset.
    int          lat      = 1;
    bit          mem_busy = 1'b0;
    int          mem_cnt  = 0;
    logic [31:0] mem_addr = 32'h0;
    always @(posedge CLK) begin
        #1;
        if (imem_ack) mem_busy = 1'b0;
        if (!mem_busy && imem_req === 1'b1) begin
            mem_busy = 1'b1;
            mem_cnt  = 0;
            mem_addr = imem_addr;
        end
        if (mem_busy) mem_cnt++;
        imem_ack   = mem_busy && (mem_cnt >= lat);
        imem_rdata = imem_ack ? instr_of(mem_addr) : 32'hDEAD_BEEF;
    end

    // Reference model: queue of fetched pairs plus request bookkeeping.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } entry_t;
    entry_t      mq[$];
    bit          m_req  = 1'b0;
    bit          m_drop = 1'b0;
    logic [31:0] m_addr = RESET_PC;

    always @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            mq.delete();
            m_req  = 1'b0;
            m_drop = 1'b0;
            m_addr = RESET_PC;
        end else begin : step
            int n;
            bit do_pop;
            bit do_push;
            n       = mq.size();
            do_pop  = (n > 0) && !IDStall && !Flush;
            do_push = m_req && imem_ack && !Flush;
            if (Flush) mq.delete();
            else begin
                if (do_pop)  void'(mq.pop_front());
                if (do_push) mq.push_back('{pc: m_addr, ir: instr_of(m_addr)});
            end
            if (m_drop) begin
                if (imem_ack) m_drop = 1'b0;
            end else if (!m_req) begin
                if (!Flush && n < DEPTH) begin
                    m_req  = 1'b1;
                    m_addr = FetchPC & 32'hFFFF_FFFC;
                end
            end else if (imem_ack) begin
                if (Flush || mq.size() >= DEPTH) m_req = 1'b0;
                else                             m_addr = m_addr + 32'd4;
            end else if (Flush) begin
                m_req  = 1'b0;
                m_drop = 1'b1;
            end
        end
    end

    always @(negedge CLK) begin : compare
        logic        e_valid;
        logic [31:0] e_ir;
        logic [31:0] e_pc;
        logic        e_frz;
        if (cmp_en) begin
            e_valid = (mq.size() > 0);
            e_ir    = e_valid ? mq[0].ir : 32'h0;
            e_pc    = e_valid ? mq[0].pc : 32'h0;
            e_frz   = !(Reset && (Flush || (m_req && imem_ack)));
            check1 ("imem_req",  imem_req,  m_req);
            check32("imem_addr", imem_addr, m_addr);
            check1 ("IRValid",   IRValid,   e_valid);
            check32("IR",        IR,        e_ir);
            check32("IRPC",      IRPC,      e_pc);
            check1 ("PCFrozen",  PCFrozen,  e_frz);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic do_reset(input int l, input logic stall);
        tick();
        Reset   = 1'b0;
        Flush   = 1'b0;
        IDStall = stall;
        lat     = l;
        tick();
        tick();
        for (int i = 0; i < 20 && mem_busy; i++) tick();
        Reset = 1'b1;
    endtask

    task automatic wait_req(input logic [31:0] addr, input string name);
        bit found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge CLK);
            if (imem_req === 1'b1 && imem_addr === addr) found = 1'b1;
        end
        n_assert++;
        if (!found) begin
            n_fail++;
            $display("FAIL %s: no request to %08h within 50 cycles (addr now %08h)", name, addr, imem_addr);
        end
    endtask

    task automatic wait_valid(input string name);
        bit found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge CLK);
            if (IRValid === 1'b1) found = 1'b1;
        end
        n_assert++;
        if (!found) begin
            n_fail++;
            $display("FAIL %s: IRValid not seen within 50 cycles", name);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        @(posedge CLK);
        #1 cmp_en = 1'b1;
        repeat (2) @(negedge CLK);
        check1 ("reset imem_req",  imem_req,  1'b0);
        check32("reset imem_addr", imem_addr, 32'h0000_3000);
        check1 ("reset IRValid",   IRValid,   1'b0);
        check32("reset IR",        IR,        32'h0);
        check32("reset IRPC",      IRPC,      32'h0);
        check1 ("reset PCFrozen",  PCFrozen,  1'b1);
        tick();
        Reset = 1'b1;

        // Zero-wait streaming
        @(negedge CLK);
        check1 ("t1 idle req", imem_req, 1'b0);
        @(negedge CLK);
        check32("t1 addr0", imem_addr, 32'h0000_3000);
        check1 ("t1 frz0",  PCFrozen,  1'b0);
        @(negedge CLK);
        check32("t1 addr1", imem_addr, 32'h0000_3004);
        check32("t1 irpc1", IRPC,      32'h0000_3000);
        check1 ("t1 frz1",  PCFrozen,  1'b0);
        @(negedge CLK);
        check32("t1 addr2", imem_addr, 32'h0000_3008);
        check32("t1 irpc2", IRPC,      32'h0000_3004);
        check32("t1 ir2",   IR,        instr_of(32'h0000_3004));

        // Decode stalled: queue fills to DEPTH, then fetch resumes after a pop
        do_reset(1, 1'b1);
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (imem_req && imem_ack) acks++;
        end
        check32("t2 pushes",   32'(acks), 32'd4);
        check1 ("t2 req low",  imem_req,  1'b0);
        check1 ("t2 frozen",   PCFrozen,  1'b1);
        check1 ("t2 valid",    IRValid,   1'b1);
        check32("t2 head",     IRPC,      32'h0000_3000);
        tick();
        IDStall = 1'b0;
        @(negedge CLK);
        check32("t2 first pop", IRPC, 32'h0000_3000);
        wait_req(32'h0000_3010, "t2 resume");

        // Three-cycle memory latency
        do_reset(3, 1'b0);
        @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check32("t3 addr stable", imem_addr, 32'h0000_3000);
            check1 ("t3 frozen",      PCFrozen,  (i != 2));
        end
        @(negedge CLK);
        check32("t3 next addr", imem_addr, 32'h0000_3004);

        // Flush while a request is outstanding: DROP discards the late data
        do_reset(4, 1'b0);
        wait_req(32'h0000_3008, "t4 req 3008");
        tick();
        Flush        = 1'b1;
        flush_target = 32'h0000_3100;
        tick();
        Flush = 1'b0;
        @(negedge CLK);
        check1("t4 req dropped", imem_req, 1'b0);
        check1("t4 empty",       IRValid,  1'b0);
        wait_req(32'h0000_3100, "t4 redirect");
        wait_valid("t4 valid");
        check32("t4 head pc", IRPC, 32'h0000_3100);
        check32("t4 head ir", IR,   instr_of(32'h0000_3100));

        // Flush coincident with ack
        do_reset(2, 1'b1);
        wait_req(32'h0000_3004, "t5 req 3004");
        tick();
        Flush        = 1'b1;
        flush_target = 32'h0000_3200;
        @(negedge CLK);
        check1("t5 ack present", imem_ack, 1'b1);
        check1("t5 frz on ack",  PCFrozen, 1'b0);
        check1("t5 valid before", IRValid, 1'b1);
        tick();
        Flush   = 1'b0;
        IDStall = 1'b0;
        @(negedge CLK);
        check1("t5 empty after", IRValid,  1'b0);
        check1("t5 req after",   imem_req, 1'b0);
        wait_req(32'h0000_3200, "t5 redirect");

        // Address wrap at the top of the 32-bit space
        tick();
        lat          = 1;
        Flush        = 1'b1;
        flush_target = 32'hFFFF_FFF8;
        tick();
        Flush = 1'b0;
        wait_req(32'hFFFF_FFF8, "t6 req fff8");
        @(negedge CLK);
        check32("t6 addr fffc", imem_addr, 32'hFFFF_FFFC);
        @(negedge CLK);
        check32("t6 addr wrap", imem_addr, 32'h0000_0000);

        // Asynchronous reset mid-request with two entries queued
        do_reset(2, 1'b1);
        wait_req(32'h0000_3008, "t7 req 3008");
        check32("t7 queued pc", IRPC, 32'h0000_3000);
        #1 Reset = 1'b0;
        #1;
        check1 ("t7 rst req",   imem_req,  1'b0);
        check32("t7 rst addr",  imem_addr, 32'h0000_3000);
        check1 ("t7 rst valid", IRValid,   1'b0);
        check32("t7 rst IR",    IR,        32'h0);
        check32("t7 rst IRPC",  IRPC,      32'h0);
        check1 ("t7 rst frz",   PCFrozen,  1'b1);
        tick();
        Reset   = 1'b1;
        IDStall = 1'b0;
        @(negedge CLK);
        check1("t7 late ack",    imem_ack, 1'b1);
        check1("t7 ack ignored", IRValid,  1'b0);
        check1("t7 idle req",    imem_req, 1'b0);
        wait_req(32'h0000_3000, "t7 refetch");
        wait_valid("t7 valid");
        check32("t7 head pc", IRPC, 32'h0000_3000);
        check32("t7 head ir", IR,   instr_of(32'h0000_3000));

        repeat (3) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
